// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
//   Two-entry ready/valid pipeline register (main + skid slot). in_ready and
//   out_data come straight from flops, so the stage breaks both the forward
//   and the backward timing paths while still moving one entry per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      drop every held entry and any entry offered this cycle
//   in_valid   upstream payload present
//   in_ready   stage can take a payload this cycle
//   in_data    upstream payload, DATA_WIDTH bits
//   out_valid  out_data holds a live entry
//   out_ready  downstream takes the head entry
//   out_data   head payload, DATA_WIDTH bits
//   occupancy  live entries: 0, 1 or 2
//
// Configuration
//   PIPELINE_STAGE_ZERO_EN  when defined, a slot is cleared to 0 whenever it
//                           is vacated or flushed, so out_data is 0 whenever
//                           out_valid is 0. When undefined, vacated slots keep
//                           stale data. Handshake timing is identical.
//
// state | meaning
// ------+--------------------------------
// EMPTY | no live entry
// ONE   | main live, skid free
// FULL  | main and skid live, in_ready=0

module pipeline_stage_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
`ifdef PIPELINE_STAGE_ZERO_EN
                    main_d  = '0;
`endif
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain case exists.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
`ifdef PIPELINE_STAGE_ZERO_EN
                    skid_d  = '0;
`endif
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush wins over everything, including a same-cycle push.
        if (flush) begin
            state_d = EMPTY;
`ifdef PIPELINE_STAGE_ZERO_EN
            main_d  = '0;
            skid_d  = '0;
`else
            main_d  = main_q;
            skid_d  = skid_q;
`endif
        end

        // Registered ready: computed from the next state so it is valid the
        // cycle the new state takes effect.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning payload width in bits; legal range 1 to 512.
REQ-002 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port flush  input  1  discards all held and incoming entries.
REQ-005 The block SHALL have port in_valid  input  1  upstream presents a payload.
REQ-006 The block SHALL have port in_ready  output  1  stage can accept a payload this cycle; driven from a register.
REQ-007 The block SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-008 The block SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-010 The block SHALL have port out_data  output  DATA_WIDTH  head payload; driven from a register.
REQ-011 The block SHALL have port occupancy  output  2  number of live entries: 0, 1 or 2.

Function
REQ-012 The block SHALL use in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-013 The block SHALL hold two entry slots, main and skid, in three states: EMPTY (no live entry), ONE (main live) and FULL (main and skid live).
REQ-014 The block SHALL drive out_valid and out_data from main, in_ready = (state != FULL), and occupancy as 0, 1 or 2 per state.
REQ-015 In EMPTY, in_fire SHALL load main from in_data and move to ONE, giving one cycle of latency from input to output.
REQ-016 In ONE, in_fire with out_fire SHALL load main from in_data and stay in ONE.
REQ-017 In ONE, in_fire without out_fire SHALL load skid from in_data and move to FULL.
REQ-018 In ONE, out_fire without in_fire SHALL move to EMPTY.
REQ-019 In FULL, out_fire SHALL copy skid into main and move to ONE; no in_fire is possible in FULL because in_ready is 0.
REQ-020 With no fire events, the block SHALL keep its state and data unchanged.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL NOT change.
REQ-022 Entries SHALL leave in arrival order; the block SHALL NOT drop or duplicate an entry except on flush.
REQ-023 flush SHALL override every other event: the next state is EMPTY, with out_valid=0, occupancy=0 and in_ready=1.
REQ-024 A payload whose in_fire occurs in the same cycle as flush SHALL be discarded.
REQ-025 Full throughput SHALL be sustained: with in_valid=1 and out_ready=1 held, one entry is transferred every cycle.

Reset
REQ-026 While rst=1, the block SHALL force state EMPTY, out_valid=0, in_ready=1, occupancy=0 and both data slots to 0, regardless of clk.
REQ-027 If rst is asserted mid-operation, all live entries SHALL be lost.
REQ-028 After rst deasserts, the first rising clk edge SHALL accept input normally.

Configuration
REQ-029 The block SHALL support the macro PIPELINE_STAGE_ZERO_EN.
REQ-030 With PIPELINE_STAGE_ZERO_EN defined, the block SHALL clear each data slot to 0 on flush and whenever that slot is vacated, so out_data is 0 whenever out_valid is 0.
REQ-031 With PIPELINE_STAGE_ZERO_EN undefined, flush and vacate SHALL clear only the valid state, and the data slots keep stale values.
REQ-032 In both configurations, handshake behaviour and timing SHALL be identical.

Verification
REQ-033 The bench SHALL drive reset then a single payload: rst pulse, in_data=32'hA5A5_0001 with in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 with out_data=32'hA5A5_0001 on the next cycle, then out_valid=0.
REQ-034 The bench SHALL check backpressure: out_ready=0, push 0x11 then 0x22 -> occupancy=2 and in_ready=0; then out_ready=1 -> outputs 0x11 then 0x22 on consecutive cycles, after which in_ready=1.
REQ-035 The bench SHALL check streaming: 8 consecutive payloads 0..7 with out_ready=1 throughout -> outputs 0..7 on 8 consecutive cycles, in_ready held at 1.
REQ-036 The bench SHALL check flush in FULL with a simultaneous push: FULL with 0x33 and 0x44, flush=1 in the same cycle as in_valid with 0x55 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x55 never appears.
REQ-037 The bench SHALL check reset mid-stream: rst asserted between clock edges while FULL -> out_valid=0 and in_ready=1 immediately, before the next clk edge.
REQ-038 The bench SHALL run REQ-036 with PIPELINE_STAGE_ZERO_EN defined -> out_data=0 after flush; undefined -> out_data retains 0x33.
